// File: rtl/pre.sv
// pre: forwards user AXI-Stream packets through one register stage, optionally appending a sequence-number beat, and counts packets sent.
module pre #(
    parameter int DATA_WIDTH = 32,
    parameter int CNTR_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] SEQ_INIT = 1
) (
    input  logic                  m_axis_aclk,
    input  logic                  m_axis_areset,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  ctrl_seq_en,
    input  logic                  ctrl_rst_seq,
    input  logic                  ctrl_rst_cntr_out,
    output logic [CNTR_WIDTH-1:0] slv_cntr_out
);
    typedef enum logic {ST_DATA, ST_SEQ} state_t;
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] seq;
    logic in_pkt, seq_en_lat, slot_free, accept, enable, seq_load;
    assign slot_free = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state == ST_DATA) && slot_free && !m_axis_areset;
    assign accept = s_axis_tvalid && s_axis_tready;
    // first beat of a packet uses the live enable so single-beat packets are covered
    assign enable = in_pkt ? seq_en_lat : ctrl_seq_en;
    assign seq_load = (state == ST_SEQ) && slot_free;
    always_comb begin
        state_n = state;
        if (accept && s_axis_tlast && enable) state_n = ST_SEQ;
        if (seq_load) state_n = ST_DATA;
    end
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            state         <= ST_DATA;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            seq           <= SEQ_INIT;
            in_pkt        <= 1'b0;
            seq_en_lat    <= 1'b0;
            slv_cntr_out  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tlast  <= s_axis_tlast && !enable;
                in_pkt        <= !s_axis_tlast;
                if (!in_pkt) seq_en_lat <= ctrl_seq_en;
            end else if (seq_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= seq;
                m_axis_tlast  <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (ctrl_rst_seq) seq <= SEQ_INIT;
            else if (seq_load) seq <= seq + DATA_WIDTH'(1);
            if (ctrl_rst_cntr_out) slv_cntr_out <= '0;
            else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) slv_cntr_out <= slv_cntr_out + CNTR_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_pre.sv
// tb_pre: directed self-checking bench for pre, with a second instance started near the sequence wrap point.
`timescale 1ns/1ps
module tb_pre;
    logic clk = 0, rst = 1;
    logic s_tvalid = 0, s_tlast = 0, m_tready = 1, seq_en = 0, rst_seq = 0, rst_cntr = 0;
    logic [31:0] s_tdata = 0;
    logic s_tready, m_tvalid, m_tlast, w_s_tready, w_m_tvalid, w_m_tlast;
    logic [31:0] m_tdata, w_m_tdata;
    logic [63:0] cntr, w_cntr;
    logic [31:0] qd[$], wd[$];
    logic ql[$], wl[$];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    pre dut (
        .m_axis_aclk(clk), .m_axis_areset(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
        .ctrl_seq_en(seq_en), .ctrl_rst_seq(rst_seq), .ctrl_rst_cntr_out(rst_cntr), .slv_cntr_out(cntr)
    );

    pre #(.SEQ_INIT(32'hFFFF_FFFF)) dut_w (
        .m_axis_aclk(clk), .m_axis_areset(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(w_s_tready), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(w_m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(w_m_tdata), .m_axis_tlast(w_m_tlast),
        .ctrl_seq_en(seq_en), .ctrl_rst_seq(rst_seq), .ctrl_rst_cntr_out(rst_cntr), .slv_cntr_out(w_cntr)
    );

    // downstream monitor: records every beat that will handshake on the coming edge
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin qd.push_back(m_tdata); ql.push_back(m_tlast); end
        if (w_m_tvalid && m_tready) begin wd.push_back(w_m_tdata); wl.push_back(w_m_tlast); end
    end

    task automatic clear_q();
        qd.delete(); ql.delete(); wd.delete(); wl.delete();
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        bit ok = 0;
        s_tvalid = 1; s_tdata = d; s_tlast = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_tready;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL send_accept data=%h got tready=0 required 1 within 50 cycles", d); end
        @(posedge clk); #1;
        s_tvalid = 0; s_tlast = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle(2);
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got %b required 0", m_tvalid); end
        checks++; if (m_tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata got %h required 0", m_tdata); end
        checks++; if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got %b required 0", m_tlast); end
        checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL reset_s_tready got %b required 0", s_tready); end
        checks++; if (cntr !== 64'd0) begin failures++; $display("FAIL reset_cntr got %0d required 0", cntr); end
        @(posedge clk); #1;
        rst = 0;
        idle(1);
        clear_q();
    endtask

    task automatic test_seq_enable();
        logic [31:0] ed[8] = '{32'hA5A5A5A5, 32'h5AA55AA5, 32'h0000C0DE, 32'h1, 32'hA5A5A5A5, 32'h5AA55AA5, 32'h0000C0DE, 32'h2};
        logic el[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        seq_en = 1; m_tready = 1;
        for (int p = 0; p < 2; p++) begin
            send(32'hA5A5A5A5, 0); send(32'h5AA55AA5, 0); send(32'h0000C0DE, 1);
            idle(4);
            checks++; if (cntr !== 64'(p + 1)) begin failures++; $display("FAIL seq_cntr pkt%0d got %0d required %0d", p, cntr, p + 1); end
        end
        checks++; if (qd.size() != 8) begin failures++; $display("FAIL seq_beats got %0d required 8", qd.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (qd[i] !== ed[i] || ql[i] !== el[i]) begin
                failures++; $display("FAIL seq_beat%0d got %h/%b required %h/%b", i, qd[i], ql[i], ed[i], el[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_disabled();
        seq_en = 0;
        send(32'h12345678, 1);
        idle(4);
        checks++; if (qd.size() != 1) begin failures++; $display("FAIL dis_beats got %0d required 1", qd.size()); end
        checks++; if (qd[0] !== 32'h12345678 || ql[0] !== 1'b1) begin failures++; $display("FAIL dis_beat got %h/%b required 12345678/1", qd[0], ql[0]); end
        checks++; if (cntr !== 64'd3) begin failures++; $display("FAIL dis_cntr got %0d required 3", cntr); end
        clear_q();
    endtask

    task automatic test_backpressure();
        seq_en = 1;
        send(32'h11111111, 1);
        @(posedge clk); #1;
        m_tready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 32'h3 || m_tlast !== 1'b1 || s_tready !== 1'b0) begin
                failures++; $display("FAIL bp_hold%0d got v=%b d=%h l=%b rdy=%b required v=1 d=00000003 l=1 rdy=0", i, m_tvalid, m_tdata, m_tlast, s_tready);
            end
        end
        @(posedge clk); #1;
        m_tready = 1;
        idle(4);
        checks++; if (qd.size() != 2) begin failures++; $display("FAIL bp_beats got %0d required 2", qd.size()); end
        checks++; if (qd[0] !== 32'h11111111 || ql[0] !== 1'b0) begin failures++; $display("FAIL bp_data got %h/%b required 11111111/0", qd[0], ql[0]); end
        checks++; if (qd[1] !== 32'h3 || ql[1] !== 1'b1) begin failures++; $display("FAIL bp_seq got %h/%b required 00000003/1", qd[1], ql[1]); end
        checks++; if (cntr !== 64'd4) begin failures++; $display("FAIL bp_cntr got %0d required 4", cntr); end
        clear_q();
    endtask

    task automatic test_toggle();
        logic [31:0] ed[5] = '{32'h21, 32'h22, 32'h23, 32'h4, 32'h24};
        logic el[5] = '{0, 0, 0, 1, 1};
        seq_en = 1;
        send(32'h21, 0);
        seq_en = 0;
        send(32'h22, 0); send(32'h23, 1); send(32'h24, 1);
        idle(4);
        checks++; if (qd.size() != 5) begin failures++; $display("FAIL tog_beats got %0d required 5", qd.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (qd[i] !== ed[i] || ql[i] !== el[i]) begin
                failures++; $display("FAIL tog_beat%0d got %h/%b required %h/%b", i, qd[i], ql[i], ed[i], el[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_wrap();
        logic [31:0] ed[6] = '{32'hAA, 32'hFFFFFFFF, 32'hBB, 32'h0, 32'hCC, 32'hFFFFFFFF};
        logic el[6] = '{0, 1, 0, 1, 0, 1};
        rst = 1; idle(2); rst = 0; idle(1);
        clear_q();
        seq_en = 1;
        send(32'hAA, 1); send(32'hBB, 1);
        idle(3);
        rst_seq = 1; idle(1); rst_seq = 0;
        send(32'hCC, 1);
        idle(4);
        checks++; if (wd.size() != 6) begin failures++; $display("FAIL wrap_beats got %0d required 6", wd.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (wd[i] !== ed[i] || wl[i] !== el[i]) begin
                failures++; $display("FAIL wrap_beat%0d got %h/%b required %h/%b", i, wd[i], wl[i], ed[i], el[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        seq_en = 1;
        send(32'h31, 0); send(32'h32, 0);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin failures++; $display("FAIL rst_mid got v=%b rdy=%b required 0/0", m_tvalid, s_tready); end
        @(posedge clk); #1;
        rst = 0;
        clear_q();
        send(32'h41, 1);
        idle(4);
        checks++; if (qd.size() != 2) begin failures++; $display("FAIL rst_mid_beats got %0d required 2", qd.size()); end
        checks++; if (qd[0] !== 32'h41 || ql[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_data got %h/%b required 00000041/0", qd[0], ql[0]); end
        checks++; if (qd[1] !== 32'h1 || ql[1] !== 1'b1) begin failures++; $display("FAIL rst_mid_seq got %h/%b required 00000001/1", qd[1], ql[1]); end
        checks++; if (cntr !== 64'd1) begin failures++; $display("FAIL rst_mid_cntr got %0d required 1", cntr); end
        send(32'h51, 1);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = m_tvalid && m_tlast && m_tready;
        end
        checks++; if (!seen) begin failures++; $display("FAIL cntr_clr_wait got no tlast beat required one within 20 cycles"); end
        rst_cntr = 1;
        @(posedge clk); #1;
        rst_cntr = 0;
        @(negedge clk);
        checks++; if (cntr !== 64'd0) begin failures++; $display("FAIL cntr_clr got %0d required 0", cntr); end
        clear_q();
    endtask

    initial begin
        test_reset();
        test_seq_enable();
        test_disabled();
        test_backpressure();
        test_toggle();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pre.md
Name: pre

Overview:
- Transmit-side counterpart of the receive-side `post` block, sitting between the user AXI-Stream source and the Aurora TX channel.
- Forwards user packets through a one-deep registered stage.
- When enabled, appends one sequence-number beat after each packet's last data beat; that beat carries tlast, so the far-end `post` can strip and check it.
- Counts packets sent.

Parameters:
- DATA_WIDTH, 32, width of tdata and of the sequence number.
- CNTR_WIDTH, 64, width of the outbound packet counter.
- SEQ_INIT, 1, sequence value loaded at reset and on ctrl_rst_seq.

Ports:
- m_axis_aclk  in  1  single clock for all logic.
- m_axis_areset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  user beat valid.
- s_axis_tready  out  1  block accepts user beat.
- s_axis_tdata  in  DATA_WIDTH  user data.
- s_axis_tlast  in  1  last user beat of packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream accepts beat.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tlast  out  1  last beat of output packet.
- ctrl_seq_en  in  1  append sequence numbers; sampled per packet.
- ctrl_rst_seq  in  1  reload sequence counter to SEQ_INIT.
- ctrl_rst_cntr_out  in  1  clear slv_cntr_out.
- slv_cntr_out  out  CNTR_WIDTH  count of output packets completed.

Behaviour:
- Reset (m_axis_areset=1 at a clock edge):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0 during reset.
  - slv_cntr_out=0, seq=SEQ_INIT, state=ST_DATA, in_pkt=0, seq_en_lat=0.
- Reset mid-packet discards the partial packet and any pending sequence beat; no recovery beat is emitted.
- Output register:
  - slot_free = !m_axis_tvalid || m_axis_tready.
  - m_axis_tvalid deasserts after a handshake only if no new beat loads that cycle.
  - m_axis_tdata and m_axis_tlast hold stable while m_axis_tvalid && !m_axis_tready.
- s_axis_tready = (state==ST_DATA) && slot_free && !reset. This is a combinational path from m_axis_tready, which is accepted.
- Latency: an accepted user beat appears on m_axis one cycle after acceptance. Full throughput of 1 beat/clk with m_axis_tready held high.
- Per-packet enable:
  - On the first accepted beat of a packet (in_pkt=0), seq_en_lat <= ctrl_seq_en. This value is used for that beat, so single-beat packets behave correctly.
  - Toggling ctrl_seq_en mid-packet has no effect until the next packet.
  - in_pkt sets on any accepted beat without tlast and clears on an accepted tlast beat.
- State ST_DATA:
  - Accepted beat with !s_axis_tlast: load tdata, tlast=0.
  - Accepted beat with s_axis_tlast && !enable: load tdata, tlast=1; stay in ST_DATA.
  - Accepted beat with s_axis_tlast && enable: load tdata, tlast=0; go to ST_SEQ.
- State ST_SEQ:
  - s_axis_tready=0.
  - When slot_free: load m_axis_tdata=seq, tlast=1, seq<=seq+1, go to ST_DATA.
  - The sequence beat is emitted on the cycle after the last data beat if downstream is ready. This gives exactly one bubble on the user side per enabled packet.
- Sequence arithmetic:
  - Modulo 2^DATA_WIDTH; 0xFFFFFFFF wraps to 0x00000000. SEQ_INIT is not reapplied on wrap.
- ctrl_rst_seq:
  - seq <= SEQ_INIT at the next edge, overriding any increment.
  - A sequence beat loaded on that same edge carries the old value.
- Packet counter:
  - slv_cntr_out increments on each m_axis handshake with m_axis_tlast=1.
  - Wraps at 2^CNTR_WIDTH.
  - ctrl_rst_cntr_out forces 0 and wins over a simultaneous increment.

Test Plan:
- Enable=1, seq=1 after reset, 3-beat packet A5A5A5A5, 5AA55AA5, 0000C0DE, m_axis_tready=1 -> output 4 beats: the three data beats with tlast=0, then 00000001 with tlast=1; slv_cntr_out=1. A second identical packet -> trailing beat 00000002.
- Enable=0, single-beat packet 12345678 with tlast -> one output beat 12345678 with tlast=1, no appended beat, seq unchanged, slv_cntr_out increments.
- Backpressure: m_axis_tready held 0 for 4 cycles during the sequence beat -> m_axis_tdata/tlast stable, s_axis_tready=0 throughout; beat delivered once on release, no duplication or loss.
- ctrl_seq_en toggled 1->0 on beat 2 of 3 -> that packet still gets its sequence beat; the next packet gets none.
- Force seq=FFFFFFFF via SEQ_INIT=32'hFFFFFFFF, send two enabled packets -> trailing beats FFFFFFFF then 00000000. ctrl_rst_seq pulse -> next trailing beat is FFFFFFFF.
- Reset asserted mid-packet after 2 beats, then released -> m_axis_tvalid=0 on the reset cycle; next packet's sequence beat equals SEQ_INIT. ctrl_rst_cntr_out coincident with a tlast handshake -> slv_cntr_out=0.
